// File: rtl/float_class_pipe.sv
// Streaming multi-lane float classifier: one register stage, valid/ready on both sides,
// RISC-V fclass one-hot codes, sticky exception flags and a saturating NaN counter.
// Define FLOAT_CLASS_DAZ_EN to classify subnormal inputs as zero of the same sign.
module float_class_pipe #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int LANES          = 1,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [LANES*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)-1:0] in_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [LANES*10-1:0]                                out_class,
  output logic [3:0]                                         sticky_flags,
  output logic [COUNT_WIDTH-1:0]                             nan_count,
  input  logic                                               sticky_clear
);

  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;
  localparam int W = E + M + 1;

  // Small MX formats reuse the all-ones exponent for ordinary values.
  localparam bit IS_E4M3    = (E == 4) && (M == 3);
  localparam bit NO_SPECIAL = ((E == 2) && (M == 3)) || ((E == 3) && (M == 2)) ||
                              ((E == 2) && (M == 1));

  localparam int NW = $clog2(LANES + 1);
  localparam int SW = ((COUNT_WIDTH > NW) ? COUNT_WIDTH : NW) + 1;
  localparam logic [SW-1:0] CNT_MAX = {{(SW-COUNT_WIDTH){1'b0}}, {COUNT_WIDTH{1'b1}}};

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  function automatic logic [9:0] classify(input logic [W-1:0] f);
    logic         sign;
    logic [E-1:0] exp_f;
    logic [M-1:0] mant;
    logic         exp_zero, exp_ones, mant_zero;
    logic         is_nan, is_qnan, is_inf, is_zero, is_sub;
    logic [9:0]   c;
    sign      = f[W-1];
    exp_f     = f[W-2 -: E];
    mant      = f[M-1:0];
    exp_zero  = (exp_f == '0);
    exp_ones  = &exp_f;
    mant_zero = (mant == '0);
    if (NO_SPECIAL) begin
      is_inf  = 1'b0;
      is_nan  = 1'b0;
      is_qnan = 1'b0;
    end else if (IS_E4M3) begin
      is_inf  = 1'b0;
      is_nan  = exp_ones && (&mant);
      is_qnan = is_nan;
    end else begin
      is_inf  = exp_ones && mant_zero;
      is_nan  = exp_ones && !mant_zero;
      is_qnan = is_nan && mant[M-1];
    end
`ifdef FLOAT_CLASS_DAZ_EN
    is_zero = exp_zero;
    is_sub  = 1'b0;
`else
    is_zero = exp_zero && mant_zero;
    is_sub  = exp_zero && !mant_zero;
`endif
    c = '0;
    if (is_nan)       c[is_qnan ? CLS_QNAN : CLS_SNAN]        = 1'b1;
    else if (is_inf)  c[sign ? CLS_NEG_INF  : CLS_POS_INF]    = 1'b1;
    else if (is_zero) c[sign ? CLS_NEG_ZERO : CLS_POS_ZERO]   = 1'b1;
    else if (is_sub)  c[sign ? CLS_NEG_SUB  : CLS_POS_SUB]    = 1'b1;
    else              c[sign ? CLS_NEG_NORM : CLS_POS_NORM]   = 1'b1;
    return c;
  endfunction

  logic                   valid_q, valid_d;
  logic [LANES*10-1:0]    class_q, class_d;
  logic [3:0]             flags_q, flags_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [3:0]             beat_flags;
  logic [NW-1:0]          beat_nans;
  logic                   xfer_in;

  assign in_ready = !valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    logic [9:0] lane_c;
    class_d    = '0;
    beat_flags = '0;
    beat_nans  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_c                 = classify(in_data[i*W +: W]);
      class_d[i*10 +: 10]    = lane_c;
      beat_flags[3]          = beat_flags[3] | lane_c[CLS_SNAN];
      beat_flags[2]          = beat_flags[2] | lane_c[CLS_QNAN];
      beat_flags[1]          = beat_flags[1] | lane_c[CLS_NEG_INF] | lane_c[CLS_POS_INF];
      beat_flags[0]          = beat_flags[0] | lane_c[CLS_NEG_SUB] | lane_c[CLS_POS_SUB];
      beat_nans              = beat_nans + NW'(lane_c[CLS_SNAN] | lane_c[CLS_QNAN]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (xfer_in)
      valid_d = 1'b1;
    else if (valid_q && out_ready)
      valid_d = 1'b0;
  end

  // Clear is applied before the accepted beat's contribution is merged in.
  always_comb begin
    logic [3:0]             flags_base;
    logic [COUNT_WIDTH-1:0] count_base;
    logic [SW-1:0]          count_sum;
    flags_base = sticky_clear ? 4'b0 : flags_q;
    count_base = sticky_clear ? '0 : count_q;
    flags_d    = flags_base;
    count_sum  = SW'(count_base);
    if (xfer_in) begin
      flags_d   = flags_base | beat_flags;
      count_sum = SW'(count_base) + SW'(beat_nans);
    end
    count_d = (count_sum > CNT_MAX) ? '1 : count_sum[COUNT_WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      class_q <= '0;
      flags_q <= 4'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (xfer_in)
        class_q <= class_d;
      flags_q <= flags_d;
      count_q <= count_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_class    = class_q;
  assign sticky_flags = flags_q;
  assign nan_count    = count_q;

endmodule

// File: tb/tb_float_class_pipe.sv
// Bench for float_class_pipe: FP32 lane with a reference model checked every cycle,
// plus exhaustive small-format instances and a saturating-counter instance.
module tb_float_class_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Class code straight from the format rules, using integer field arithmetic.
  function automatic logic [9:0] ref_class(input int e, input int m, input logic [31:0] bits);
    int  maxe, maxm, ex, ma, idx;
    bit  s, mx_none, e4m3;
    maxe    = (1 << e) - 1;
    maxm    = (1 << m) - 1;
    ex      = int'((bits >> m) & 32'(maxe));
    ma      = int'(bits & 32'(maxm));
    s       = bits[e+m];
    mx_none = (e == 2 && m == 3) || (e == 3 && m == 2) || (e == 2 && m == 1);
    e4m3    = (e == 4 && m == 3);
    if (ex == maxe && !mx_none && (e4m3 ? (ma == maxm) : (ma != 0)))
      idx = (e4m3 || (((ma >> (m - 1)) & 1) == 1)) ? 9 : 8;
    else if (ex == maxe && !mx_none && !e4m3 && ma == 0)
      idx = s ? 0 : 7;
    else if (ex == 0)
      idx = (ma == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else
      idx = s ? 1 : 6;
    return 10'd1 << idx;
  endfunction

  // ---------------- dut0: FP32, 1 lane ----------------
  logic        v0 = 1'b0, rdy0, ov0, or0 = 1'b1, sc0 = 1'b0;
  logic [31:0] d0 = '0;
  logic [9:0]  c0;
  logic [3:0]  f0;
  logic [15:0] n0;

  float_class_pipe #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .LANES(1), .COUNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_class(c0), .sticky_flags(f0),
    .nan_count(n0), .sticky_clear(sc0));

  // ---------------- dut1: E4M3, 2 lanes ----------------
  logic        v1 = 1'b0, rdy1, ov1;
  logic        or1 = 1'b1, sc1 = 1'b0;
  logic [15:0] d1 = '0;
  logic [19:0] c1;
  logic [3:0]  f1;
  logic [15:0] n1;

  float_class_pipe #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3), .LANES(2), .COUNT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_class(c1), .sticky_flags(f1),
    .nan_count(n1), .sticky_clear(sc1));

  // ---------------- dut2: FP32, 4 lanes, 2-bit counter ----------------
  logic         v2 = 1'b0, rdy2, ov2;
  logic         or2 = 1'b1, sc2 = 1'b0;
  logic [127:0] d2 = '0;
  logic [39:0]  c2;
  logic [3:0]   f2;
  logic [1:0]   n2;

  float_class_pipe #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .LANES(4), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_class(c2), .sticky_flags(f2),
    .nan_count(n2), .sticky_clear(sc2));

  // ---------------- dut3: E2M1, 1 lane ----------------
  logic       v3 = 1'b0, rdy3, ov3;
  logic       or3 = 1'b1, sc3 = 1'b0;
  logic [3:0] d3 = '0;
  logic [9:0] c3;
  logic [3:0] f3;
  logic [7:0] n3;

  float_class_pipe #(.EXPONENT_WIDTH(2), .MANTISSA_WIDTH(1), .LANES(1), .COUNT_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .out_valid(ov3), .out_ready(or3), .out_class(c3), .sticky_flags(f3),
    .nan_count(n3), .sticky_clear(sc3));

  // ---------------- dut4: E5M2, 1 lane ----------------
  logic       v4 = 1'b0, rdy4, ov4;
  logic       or4 = 1'b1, sc4 = 1'b0;
  logic [7:0] d4 = '0;
  logic [9:0] c4;
  logic [3:0] f4;
  logic [7:0] n4;

  float_class_pipe #(.EXPONENT_WIDTH(5), .MANTISSA_WIDTH(2), .LANES(1), .COUNT_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .out_valid(ov4), .out_ready(or4), .out_class(c4), .sticky_flags(f4),
    .nan_count(n4), .sticky_clear(sc4));

  // ---------------- reference model for dut0 ----------------
  logic        m_valid;
  logic [9:0]  m_class;
  logic [3:0]  m_flags;
  int          m_count;

  always @(posedge clk or negedge rst_n) begin
    logic       xin;
    logic [9:0] k;
    logic [3:0] fl;
    int         cnt;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_class <= '0;
      m_flags <= '0;
      m_count <= 0;
    end else begin
      xin = v0 && (!m_valid || or0);
      k   = ref_class(8, 23, d0);
      fl  = sc0 ? 4'b0 : m_flags;
      cnt = sc0 ? 0 : m_count;
      if (xin) begin
        fl  = fl | {k[8], k[9], k[0] | k[7], k[2] | k[5]};
        cnt = cnt + ((k[8] | k[9]) ? 1 : 0);
        if (cnt > 65535) cnt = 65535;
      end
      m_flags <= fl;
      m_count <= cnt;
      if (xin) begin
        m_valid <= 1'b1;
        m_class <= k;
      end else if (m_valid && or0) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare dut0 against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp out_valid", 64'(ov0), 64'(m_valid));
      check("cmp in_ready", 64'(rdy0), 64'(!m_valid || or0));
      check("cmp out_class", 64'(c0), 64'(m_class));
      check("cmp sticky_flags", 64'(f0), 64'(m_flags));
      check("cmp nan_count", 64'(n0), 64'(m_count));
    end
  end

  function automatic logic [31:0] rand_fp32();
    logic [7:0]  ex;
    logic [22:0] ma;
    case ($urandom_range(0, 3))
      0:       ex = 8'h00;
      1:       ex = 8'hFF;
      default: ex = 8'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0:       ma = 23'h0;
      1:       ma = 23'h1;
      2:       ma = 23'h400000;
      3:       ma = 23'h3FFFFF;
      default: ma = 23'($urandom);
    endcase
    return {1'($urandom), ex, ma};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [31:0] data);
    v0 = 1'b1;
    d0 = data;
    step();
  endtask

  initial begin
    #2;
    check("reset out_valid", 64'(ov0), 64'd0);
    check("reset out_class", 64'(c0), 64'd0);
    check("reset flags", 64'(f0), 64'd0);
    check("reset count", 64'(n0), 64'd0);
    #10 rst_n = 1'b1;
    step();

    // E4M3 two-lane literal beat, then every code in both lanes
    v1 = 1'b1;
    d1 = {8'hFF, 8'h78};
    step();
    check("e4m3 lane0 +normal", 64'(c1[9:0]), 64'h040);
    check("e4m3 lane1 qnan", 64'(c1[19:10]), 64'h200);
    check("e4m3 flags no inf", 64'(f1), 64'b0100);
    check("e4m3 count", 64'(n1), 64'd1);
    for (int v = 0; v < 256; v++) begin
      d1 = {8'(255 - v), 8'(v)};
      step();
      check("e4m3 lane0 sweep", 64'(c1[9:0]), 64'(ref_class(4, 3, 32'(v))));
      check("e4m3 lane1 sweep", 64'(c1[19:10]), 64'(ref_class(4, 3, 32'(255 - v))));
    end
    v1 = 1'b0;
    check("e4m3 flags after sweep", 64'(f1), 64'b0101);
    check("e4m3 count after sweep", 64'(n1), 64'd5);

    // E2M1 literal and sweep
    v3 = 1'b1;
    d3 = 4'b0110;
    step();
    check("e2m1 0110 +normal", 64'(c3), 64'h040);
    for (int v = 0; v < 16; v++) begin
      d3 = 4'(v);
      step();
      check("e2m1 sweep", 64'(c3), 64'(ref_class(2, 1, 32'(v))));
    end
    v3 = 1'b0;
    check("e2m1 flags", 64'(f3), 64'b0001);
    check("e2m1 count", 64'(n3), 64'd0);

    // E5M2 follows IEEE rules
    v4 = 1'b1;
    d4 = 8'h7C; step(); check("e5m2 +inf", 64'(c4), 64'h080);
    d4 = 8'h7D; step(); check("e5m2 snan", 64'(c4), 64'h100);
    d4 = 8'h7E; step(); check("e5m2 qnan", 64'(c4), 64'h200);
    for (int v = 0; v < 256; v++) begin
      d4 = 8'(v);
      step();
      check("e5m2 sweep", 64'(c4), 64'(ref_class(5, 2, 32'(v))));
    end
    v4 = 1'b0;
    check("e5m2 flags", 64'(f4), 64'b1111);
    check("e5m2 count", 64'(n4), 64'd8);

    // Saturation on a 2-bit counter with 4 NaN lanes per beat
    v2 = 1'b1;
    d2 = {4{32'h7FC00000}};
    step();
    check("sat count first beat", 64'(n2), 64'd3);
    check("sat lane3 qnan", 64'(c2[39:30]), 64'h200);
    step();
    step();
    v2 = 1'b0;
    check("sat count holds", 64'(n2), 64'd3);
    check("sat flags", 64'(f2), 64'b0100);

    // FP32 directed sequence
    or0 = 1'b1;
    send0(32'h7F800000); check("fp32 +inf", 64'(c0), 64'h080);
    send0(32'hFF800001); check("fp32 snan", 64'(c0), 64'h100);
    send0(32'h7FC00000); check("fp32 qnan", 64'(c0), 64'h200);
    send0(32'h00000001); check("fp32 +sub", 64'(c0), 64'h020);
    check("fp32 flags", 64'(f0), 64'b1111);
    check("fp32 count", 64'(n0), 64'd2);

    // Backpressure
    send0(32'h3F800000);
    check("bp accepted", 64'(c0), 64'h040);
    or0 = 1'b0;
    d0  = 32'h7F800000;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp in_ready low", 64'(rdy0), 64'd0);
      step();
      check("bp out_valid held", 64'(ov0), 64'd1);
      check("bp out_class held", 64'(c0), 64'h040);
    end
    v0  = 1'b0;
    or0 = 1'b1;
    #1;
    check("bp in_ready released", 64'(rdy0), 64'd1);
    step();
    check("bp drained", 64'(ov0), 64'd0);
    check("bp class retained", 64'(c0), 64'h040);

    // Bring count to 5, then clear together with a zero beat
    send0(32'h7FC00000);
    send0(32'h7FC00000);
    send0(32'h7FC00000);
    check("pre-clear count", 64'(n0), 64'd5);
    check("pre-clear flags", 64'(f0), 64'b1111);
    sc0 = 1'b1;
    send0(32'h00000000);
    sc0 = 1'b0;
    v0  = 1'b0;
    check("clear+beat flags", 64'(f0), 64'd0);
    check("clear+beat count", 64'(n0), 64'd0);
    check("clear+beat class", 64'(c0), 64'h010);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      v0  = ($urandom_range(0, 3) != 0);
      or0 = ($urandom_range(0, 3) != 0);
      sc0 = ($urandom_range(0, 39) == 0);
      d0  = rand_fp32();
      step();
    end
    v0  = 1'b0;
    sc0 = 1'b0;
    or0 = 1'b1;
    step();

    // Async reset with a beat in flight
    or0 = 1'b0;
    send0(32'h7FC00000);
    v0 = 1'b0;
    check("pre-reset out_valid", 64'(ov0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(ov0), 64'd0);
    check("async reset flags", 64'(f0), 64'd0);
    check("async reset count", 64'(n0), 64'd0);
    check("async reset class", 64'(c0), 64'd0);
    #3 rst_n = 1'b1;
    or0 = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_class_pipe.md
Name: float_class_pipe

Overview:
Streaming, multi-lane floating-point classifier with one registered pipeline stage and a valid/ready handshake on both sides. Each accepted beat carries LANES packed floats. Every lane gets a 10-bit one-hot class code in RISC-V fclass layout. The block also keeps sticky exception flags and a saturating NaN counter, and sits between operand fetch and the FP datapath / status CSR logic.

Parameters:
EXPONENT_WIDTH, 8, exponent field width (>=2)
MANTISSA_WIDTH, 23, stored mantissa width (>=1)
LANES, 1, floats per beat (>=1)
COUNT_WIDTH, 16, width of nan_count

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  LANES*(EXPONENT_WIDTH+MANTISSA_WIDTH+1)  lane i at bits [i*W +: W], W=E+M+1, each {sign,exp,mant}
out_valid  output  1  out_class holds a valid beat
out_ready  input  1  downstream accepts
out_class  output  LANES*10  lane i at [i*10 +: 10], one-hot class
sticky_flags  output  4  {any_snan, any_qnan, any_inf, any_subnormal}
nan_count  output  COUNT_WIDTH  saturating count of NaN lanes
sticky_clear  input  1  synchronous clear of sticky_flags and nan_count

Behaviour:
- Reset (async assert, sync deassert assumed upstream): out_valid=0, out_class=0, sticky_flags=0, nan_count=0. Any in-flight beat is discarded.
- Handshake: in_ready = !out_valid || out_ready, purely combinational from out_ready. Transfer-in when in_valid && in_ready. Transfer-out when out_valid && out_ready.
- Latency 1 cycle. Throughput 1 beat/cycle under continuous out_ready=1.
- On transfer-in: out_class <= classify(in_data) and out_valid <= 1. Otherwise, on transfer-out, out_valid <= 0 and out_class holds its last value.
- While out_valid=1 and out_ready=0, out_class is stable and in_ready=0.
- Class bits: 0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN. Exactly one bit is set per lane.
- IEEE rules (default formats):
  - exp=0, mant=0 is zero.
  - exp=0, mant!=0 is subnormal.
  - exp=all-ones, mant=0 is inf.
  - exp=all-ones, mant!=0 is NaN: qNaN if mant MSB=1, else sNaN. Sign is ignored for NaN.
  - Everything else is normal.
- MX rules, selected at elaboration by (E,M):
  - (4,3) E4M3: no inf. NaN only for exp=all-ones and mant=all-ones, classified as qNaN. Other exp=all-ones values are normal.
  - (2,3), (3,2), (2,1): no inf and no NaN. Exp=all-ones values are normal.
  - (5,2) uses IEEE rules.
- Sticky/counter update happens on transfer-in, using the beat's classes:
  - any_snan |= any lane sNaN; any_qnan |= any lane qNaN; any_inf |= any lane inf; any_subnormal |= any lane subnormal.
  - nan_count += number of NaN lanes (0..LANES), saturating at all-ones with no wrap. The adder is wide enough for LANES before saturation.
- sticky_clear:
  - On its own, flags and count go to 0 the next cycle.
  - Simultaneous with transfer-in: clear applies first, then the new beat's contribution (the result equals that beat alone).
  - sticky_clear has no effect on the data path.

Optional Feature:
FLOAT_CLASS_DAZ_EN:
- Defined: denormals-are-zero. Subnormal inputs are classified as zero of the same sign (bit 3 or 4). any_subnormal never sets and stays 0.
- Undefined: subnormals are classified and flagged as above.

Test Plan:
- FP32, LANES=1: in_data=0x7F800000, then 0xFF800001, then 0x7FC00000, then 0x00000001 with out_ready=1. Required out_class, one cycle after each: 0x080, 0x100, 0x200, 0x020. sticky_flags=4'b1111 and nan_count=2 after the last beat.
- Backpressure: FP32 0x3F800000 accepted, out_ready=0 for 3 cycles. Required: out_class=0x040 and out_valid=1 stable, in_ready=0 throughout. out_ready=1 then gives transfer-out and in_ready=1 the same cycle.
- E4M3, LANES=2: in_data={8'hFF, 8'h78}. Required lane0=0x040 (normal, 8'h78 is positive), lane1=0x200 (qNaN), no inf flag. For E2M1 input 4'b0110: +normal, 0x040.
- Saturation: LANES=4, COUNT_WIDTH=2, each beat with all 4 lanes FP32 0x7FC00000. Required nan_count=3 after the first beat, stays 3 afterwards.
- sticky_clear asserted in the same cycle as transfer-in of FP32 0x00000000 after flags=4'b1111, nan_count=5. Required flags=0 and count=0 next cycle.
- Async reset: assert rst_n=0 mid-stream with out_valid=1. Required: out_valid=0, flags=0, count=0 immediately, with no clock edge needed.
